placar_controle: RTL and testbench



---
 rtl/placar_controle.sv | 188 ++++++++++++++++++
 tb/tb_placar_controle.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/placar_controle.sv
// Two-team scoreboard controller: button edges become +/-1..3 point operations
// executed through an external shared adder, with range checking and an alarm pulse.
module placar_controle #(
    parameter int MAX_PONTOS    = 99,
    parameter int ALARME_CICLOS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       btn_c,
    input  logic       sub_sel,
    input  logic       team_sel,
    input  logic       clr,
    output logic [6:0] add_a,
    output logic [1:0] add_b,
    output logic       add_cin,
    input  logic [6:0] add_s,
    input  logic       add_cout,
    output logic [6:0] score_t0,
    output logic [6:0] score_t1,
    output logic       busy,
    output logic       done,
    output logic       alarm
);

    localparam int CW = (ALARME_CICLOS < 1) ? 1 : $clog2(ALARME_CICLOS + 1);
    localparam logic [6:0]    MAX_S    = 7'(MAX_PONTOS);
    localparam logic [CW-1:0] ALM_LOAD = CW'(ALARME_CICLOS);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        state_r, state_s;
    logic [2:0]    btn_r, btn_prev_r, evt_s;
    logic [1:0]    pts_r, pts_s;
    logic          sub_r, sub_s, team_r, team_s;
    logic [6:0]    t0_r, t0_s, t1_r, t1_s;
    logic [6:0]    add_a_r, add_a_s;
    logic [1:0]    add_b_r, add_b_s;
    logic          add_cin_r, add_cin_s;
    logic          busy_r, busy_s, done_r, done_s, alarm_r, alarm_s;
    logic [CW-1:0] alm_cnt_r, alm_cnt_s;
    logic          accept_s, reject_s;

    // Highest-weight button wins when several edges land together.
    function automatic logic [1:0] prio_pts(input logic [2:0] ev);
        logic [1:0] p;
        if (ev[2]) begin
            p = 2'd3;
        end else if (ev[1]) begin
            p = 2'd2;
        end else begin
            p = 2'd1;
        end
        return p;
    endfunction

    assign evt_s = btn_r & ~btn_prev_r;

    // Range check of the shared adder result for the latched operation.
    always_comb begin
        accept_s = 1'b0;
        if (sub_r) begin
            accept_s = add_cout;
        end else begin
            accept_s = (add_cout == 1'b0) && (add_s <= MAX_S);
        end
    end

    // Next-state and next-output logic of the operation FSM.
    always_comb begin
        state_s   = state_r;
        pts_s     = pts_r;
        sub_s     = sub_r;
        team_s    = team_r;
        t0_s      = t0_r;
        t1_s      = t1_r;
        add_a_s   = 7'd0;
        add_b_s   = 2'd0;
        add_cin_s = 1'b0;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        reject_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (clr) begin
                    t0_s = 7'd0;
                    t1_s = 7'd0;
                end else if (evt_s != 3'b000) begin
                    pts_s     = prio_pts(evt_s);
                    sub_s     = sub_sel;
                    team_s    = team_sel;
                    state_s   = EXEC;
                    busy_s    = 1'b1;
                    add_a_s   = team_sel ? t1_r : t0_r;
                    add_b_s   = prio_pts(evt_s);
                    add_cin_s = sub_sel;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                state_s = DONE;
                busy_s  = 1'b1;
                done_s  = 1'b1;
                if (accept_s) begin
                    if (team_r) begin
                        t1_s = add_s;
                    end else begin
                        t0_s = add_s;
                    end
                end else begin
                    reject_s = 1'b1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Alarm countdown; a fresh rejection reloads the full length.
    always_comb begin
        alm_cnt_s = alm_cnt_r;
        if (reject_s) begin
            alm_cnt_s = ALM_LOAD;
        end else if (alm_cnt_r != {CW{1'b0}}) begin
            alm_cnt_s = alm_cnt_r - CW'(1);
        end else begin
            alm_cnt_s = {CW{1'b0}};
        end
        alarm_s = (alm_cnt_s != {CW{1'b0}});
    end

    // State, button history, scores and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            btn_r      <= 3'b000;
            btn_prev_r <= 3'b000;
            pts_r      <= 2'd0;
            sub_r      <= 1'b0;
            team_r     <= 1'b0;
            t0_r       <= 7'd0;
            t1_r       <= 7'd0;
            add_a_r    <= 7'd0;
            add_b_r    <= 2'd0;
            add_cin_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            alarm_r    <= 1'b0;
            alm_cnt_r  <= {CW{1'b0}};
        end else begin
            state_r    <= state_s;
            btn_r      <= {btn_c, btn_b, btn_a};
            btn_prev_r <= btn_r;
            pts_r      <= pts_s;
            sub_r      <= sub_s;
            team_r     <= team_s;
            t0_r       <= t0_s;
            t1_r       <= t1_s;
            add_a_r    <= add_a_s;
            add_b_r    <= add_b_s;
            add_cin_r  <= add_cin_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            alarm_r    <= alarm_s;
            alm_cnt_r  <= alm_cnt_s;
        end
    end

    assign add_a    = add_a_r;
    assign add_b    = add_b_r;
    assign add_cin  = add_cin_r;
    assign score_t0 = t0_r;
    assign score_t1 = t1_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign alarm    = alarm_r;

endmodule

// File: tb/tb_placar_controle.sv
// Self-checking bench for placar_controle: operation-level score model compared
// every cycle, plus hand-computed literal checks of the directed scenarios.
module tb_placar_controle;

    localparam int MAX   = 99;
    localparam int ALARM = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_a = 1'b0, btn_b = 1'b0, btn_c = 1'b0;
    logic       sub_sel = 1'b0, team_sel = 1'b0, clr = 1'b0;
    logic [6:0] add_a, add_s, score_t0, score_t1;
    logic [1:0] add_b;
    logic       add_cin, add_cout, busy, done, alarm;
    logic [7:0] sum_s;

    int errors = 0;
    int checks = 0;

    placar_controle #(.MAX_PONTOS(MAX), .ALARME_CICLOS(ALARM)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c),
        .sub_sel(sub_sel), .team_sel(team_sel), .clr(clr),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .score_t0(score_t0), .score_t1(score_t1),
        .busy(busy), .done(done), .alarm(alarm)
    );

    always #5 clk = ~clk;

    // External combinational adder: a + b, or a + ~b + 1 in 7 bits.
    always_comb begin
        if (add_cin) sum_s = {1'b0, add_a} + {1'b0, ~{5'b00000, add_b}} + 8'd1;
        else         sum_s = {1'b0, add_a} + {6'b000000, add_b};
    end
    assign add_s    = sum_s[6:0];
    assign add_cout = sum_s[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Operation-level model: phase 0 idle, 1 executing, 2 completing.
    logic [2:0] m_lvl, m_prev, m_ev;
    int m_phase, m_t0, m_t1, m_pts, m_alarm, m_sc, m_res;
    bit m_sub, m_team, m_ok;

    always_comb begin
        m_ev  = m_lvl & ~m_prev;
        m_sc  = m_team ? m_t1 : m_t0;
        m_res = m_sub ? (m_sc - m_pts) : (m_sc + m_pts);
        m_ok  = (m_res >= 0) && (m_res <= MAX);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lvl <= 3'b000; m_prev <= 3'b000; m_phase <= 0; m_t0 <= 0; m_t1 <= 0;
            m_pts <= 0; m_alarm <= 0; m_sub <= 1'b0; m_team <= 1'b0;
        end else begin
            m_prev  <= m_lvl;
            m_lvl   <= {btn_c, btn_b, btn_a};
            m_alarm <= (m_alarm > 0) ? m_alarm - 1 : 0;
            case (m_phase)
                0: begin
                    if (clr) begin
                        m_t0 <= 0; m_t1 <= 0;
                    end else if (m_ev != 3'b000) begin
                        m_pts   <= m_ev[2] ? 3 : (m_ev[1] ? 2 : 1);
                        m_sub   <= sub_sel;
                        m_team  <= team_sel;
                        m_phase <= 1;
                    end
                end
                1: begin
                    m_phase <= 2;
                    if (m_ok) begin
                        if (m_team) m_t1 <= m_res; else m_t0 <= m_res;
                    end else begin
                        m_alarm <= ALARM;
                    end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("score_t0", int'(score_t0), m_t0);
        check("score_t1", int'(score_t1), m_t1);
        check("busy", int'(busy), (m_phase != 0) ? 1 : 0);
        check("done", int'(done), (m_phase == 2) ? 1 : 0);
        check("alarm", int'(alarm), (m_alarm > 0) ? 1 : 0);
        check("add_a", int'(add_a), (m_phase == 1) ? m_sc : 0);
        check("add_b", int'(add_b), (m_phase == 1) ? m_pts : 0);
        check("add_cin", int'(add_cin), (m_phase == 1 && m_sub) ? 1 : 0);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_op(input logic [2:0] b, input logic s, input logic t);
        {btn_c, btn_b, btn_a} = b;
        sub_sel  = s;
        team_sel = t;
        tick(1);
        {btn_c, btn_b, btn_a} = 3'b000;
        tick(4);
    endtask

    int acnt;

    initial begin
        rst_n = 1'b0;
        tick(3);
        check("rst_t0", int'(score_t0), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick(1);

        // +3 to team 0 with latency checks
        btn_c = 1'b1; team_sel = 1'b0; sub_sel = 1'b0;
        tick(1);
        btn_c = 1'b0;
        tick(1);
        check("s1_busy", int'(busy), 1);
        check("s1_add_b", int'(add_b), 3);
        tick(1);
        check("s1_t0", int'(score_t0), 3);
        check("s1_done", int'(done), 1);
        check("s1_t1", int'(score_t1), 0);
        tick(1);
        check("s1_done_off", int'(done), 0);
        check("s1_busy_off", int'(busy), 0);

        // team 1 to 1, then 1 - 2 rejected with an 8-cycle alarm
        do_op(3'b001, 1'b0, 1'b1);
        check("s2_t1", int'(score_t1), 1);
        btn_b = 1'b1; sub_sel = 1'b1; team_sel = 1'b1;
        tick(1);
        btn_b = 1'b0;
        tick(1);
        check("s2_alarm_pre", int'(alarm), 0);
        tick(1);
        check("s2_alarm_on", int'(alarm), 1);
        check("s2_t1_kept", int'(score_t1), 1);
        acnt = 1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (alarm) acnt++;
        end
        check("s2_alarm_len", acnt, 8);
        sub_sel = 1'b0;

        // team 0 up to 98, overflow rejected, 99 accepted, 100 rejected
        repeat (31) do_op(3'b100, 1'b0, 1'b0);
        do_op(3'b010, 1'b0, 1'b0);
        check("s3_t0_98", int'(score_t0), 98);
        do_op(3'b010, 1'b0, 1'b0);
        check("s3_reject", int'(score_t0), 98);
        check("s3_alarm", int'(alarm), 1);
        do_op(3'b001, 1'b0, 1'b0);
        check("s3_t0_99", int'(score_t0), 99);
        do_op(3'b001, 1'b0, 1'b0);
        check("s3_t0_cap", int'(score_t0), 99);
        tick(10);
        check("s3_alarm_off", int'(alarm), 0);

        // clear, simultaneous a+c, held b
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("s4_clr_t0", int'(score_t0), 0);
        check("s4_clr_t1", int'(score_t1), 0);
        do_op(3'b101, 1'b0, 1'b0);
        check("s4_prio", int'(score_t0), 3);
        btn_b = 1'b1;
        tick(20);
        btn_b = 1'b0;
        tick(4);
        check("s4_held", int'(score_t0), 5);

        // edge while busy is dropped; clr with an edge drops the edge
        do_op(3'b001, 1'b0, 1'b1);
        btn_a = 1'b1; team_sel = 1'b0;
        tick(1);
        btn_a = 1'b0;
        tick(1);
        btn_c = 1'b1;
        tick(1);
        btn_c = 1'b0;
        tick(5);
        check("s5_busy_drop", int'(score_t0), 6);
        clr = 1'b1; btn_a = 1'b1;
        tick(2);
        clr = 1'b0; btn_a = 1'b0;
        tick(4);
        check("s5_clr_t0", int'(score_t0), 0);
        check("s5_clr_t1", int'(score_t1), 0);
        check("s5_busy", int'(busy), 0);

        // reset during EXEC aborts the operation
        do_op(3'b100, 1'b0, 1'b1);
        btn_a = 1'b1; team_sel = 1'b1;
        tick(1);
        btn_a = 1'b0;
        tick(1);
        check("s6_exec", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("s6_busy", int'(busy), 0);
        check("s6_done", int'(done), 0);
        check("s6_t1", int'(score_t1), 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        do_op(3'b010, 1'b0, 1'b1);
        check("s6_resume", int'(score_t1), 2);

        // button held across reset release yields one event
        rst_n = 1'b0; btn_a = 1'b1; team_sel = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        btn_a = 1'b0;
        tick(1);
        check("s7_held_rst", int'(score_t0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
